// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB full-speed receive front-end.
package usb_rx_pkg;

   localparam int unsigned LS_W        = 2;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned BIT_CNT_W   = 3;
   localparam int unsigned RUN_CNT_W   = 3;
   localparam int unsigned STUFF_LIMIT = 6;

   // Synchronised line state, encoded as {D-, D+}
   localparam logic [LS_W-1:0] LS_SE0 = 2'b00;
   localparam logic [LS_W-1:0] LS_J   = 2'b01;
   localparam logic [LS_W-1:0] LS_K   = 2'b10;
   localparam logic [LS_W-1:0] LS_SE1 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP,
      ERR
   } rx_state_e;

   // True for the differential data states J and K
   function automatic logic is_jk(input logic [LS_W-1:0] ls);
      return (ls == LS_J) || (ls == LS_K);
   endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Pin synchroniser plus 4x-oversampling digital PLL producing one sample strobe per bit.
module usb_rx_dpll
   import usb_rx_pkg::*;
#(
   parameter int unsigned SAMPLE_PHASE = 2
)(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            usb_dp,
   input  logic            usb_dm,
   output logic [LS_W-1:0] line_state,
   output logic            sample_en
);

   localparam int unsigned PHASE_W = 2;

   logic [LS_W-1:0]    ls_meta;
   logic [PHASE_W-1:0] phase;
   logic [PHASE_W-1:0] phase_nxt_c;
   logic               jk_change_c;

   // A J<->K edge about to appear on line_state realigns the phase; SE0/SE1 never do
   always_comb begin
      jk_change_c = ((line_state == LS_J) && (ls_meta == LS_K)) ||
                    ((line_state == LS_K) && (ls_meta == LS_J));
      phase_nxt_c = jk_change_c ? '0 : phase + PHASE_W'(1);
   end

   // Two-flop synchroniser, phase counter and registered sample strobe
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ls_meta    <= LS_J;
         line_state <= LS_J;
         phase      <= '0;
         sample_en  <= 1'(SAMPLE_PHASE == 0);
      end else begin
         ls_meta    <= {usb_dm, usb_dp};
         line_state <= ls_meta;
         phase      <= phase_nxt_c;
         sample_en  <= (phase_nxt_c == PHASE_W'(SAMPLE_PHASE));
      end
   end

endmodule

// File: rtl/usb_fs_rx_frontend.sv
// USB full-speed receive front-end: NRZI decode, SYNC detect, unstuffing, EOP and
// bus-reset detect, byte assembly. Define USB_RX_ERRCNT_EN to add the err_count port.
module usb_fs_rx_frontend
   import usb_rx_pkg::*;
#(
   parameter int unsigned SAMPLE_PHASE     = 2,
   parameter int unsigned SYNC_MIN_ZEROS   = 5,
   parameter int unsigned RESET_SE0_CYCLES = 120
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              usb_dp,
   input  logic              usb_dm,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_active,
   output logic              rx_error,
   output logic [LS_W-1:0]   line_state,
   output logic              usb_reset_det
`ifdef USB_RX_ERRCNT_EN
   ,
   output logic [BYTE_W-1:0] err_count
`endif
);

   localparam int unsigned SE0_CNT_W = $clog2(RESET_SE0_CYCLES + 1);

   logic                 sample_en;
   rx_state_e            state, state_nxt;
   logic [RUN_CNT_W-1:0] zero_cnt, zero_nxt;
   logic [RUN_CNT_W-1:0] ones_cnt, ones_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_nxt;
   logic [BYTE_W-2:0]    shift_q, shift_nxt;
   logic [LS_W-1:0]      prev_jk, prev_nxt;
   logic [BYTE_W-1:0]    data_nxt;
   logic                 valid_nxt, error_nxt, active_nxt;
   logic                 nrzi_bit_c;
   logic [SE0_CNT_W-1:0] se0_cnt, se0_nxt_c;

   usb_rx_dpll #(
      .SAMPLE_PHASE (SAMPLE_PHASE)
   ) u_dpll (
      .clk        (clk),
      .reset_n    (reset_n),
      .usb_dp     (usb_dp),
      .usb_dm     (usb_dm),
      .line_state (line_state),
      .sample_en  (sample_en)
   );

   // Receive FSM next-state and output decode, evaluated on each sample strobe
   always_comb begin
      state_nxt  = state;
      zero_nxt   = zero_cnt;
      ones_nxt   = ones_cnt;
      bit_nxt    = bit_cnt;
      shift_nxt  = shift_q;
      prev_nxt   = prev_jk;
      data_nxt   = rx_data;
      valid_nxt  = 1'b0;
      error_nxt  = 1'b0;
      active_nxt = rx_active;
      nrzi_bit_c = (line_state == prev_jk);

      if (sample_en) begin
         if (is_jk(line_state)) begin
            prev_nxt = line_state;
         end
         case (state)
            IDLE: begin
               if ((line_state == LS_K) && (prev_jk == LS_J)) begin
                  state_nxt = SYNC;
                  zero_nxt  = RUN_CNT_W'(1);
               end
            end
            SYNC: begin
               if (line_state == LS_SE0) begin
                  state_nxt = IDLE;
               end else if (line_state == LS_SE1) begin
                  state_nxt = ERR;
               end else if (!nrzi_bit_c) begin
                  if (zero_cnt != '1) begin
                     zero_nxt = zero_cnt + RUN_CNT_W'(1);
                  end
               end else if (zero_cnt >= RUN_CNT_W'(SYNC_MIN_ZEROS)) begin
                  // The terminating 1 of SYNC opens the first stuffing run
                  state_nxt  = DATA;
                  active_nxt = 1'b1;
                  ones_nxt   = RUN_CNT_W'(1);
                  bit_nxt    = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
            DATA: begin
               if (line_state == LS_SE0) begin
                  state_nxt = EOP;
                  // 0 or 1 leftover bits is tolerated dribble
                  error_nxt = (bit_cnt >= BIT_CNT_W'(2));
               end else if (line_state == LS_SE1) begin
                  state_nxt = ERR;
               end else if (ones_cnt == RUN_CNT_W'(STUFF_LIMIT)) begin
                  if (nrzi_bit_c) begin
                     error_nxt = 1'b1;
                     state_nxt = ERR;
                  end else begin
                     ones_nxt = '0;
                  end
               end else begin
                  shift_nxt = {nrzi_bit_c, shift_q[BYTE_W-2:1]};
                  ones_nxt  = nrzi_bit_c ? ones_cnt + RUN_CNT_W'(1) : '0;
                  bit_nxt   = bit_cnt + BIT_CNT_W'(1);
                  if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                     valid_nxt = 1'b1;
                     data_nxt  = {nrzi_bit_c, shift_q};
                  end
               end
            end
            EOP: begin
               if (line_state == LS_J) begin
                  state_nxt  = IDLE;
                  active_nxt = 1'b0;
               end else if (line_state != LS_SE0) begin
                  state_nxt = ERR;
               end
            end
            ERR: begin
               // After an error the frame still needs a clean SE0-then-J to close
               if (line_state == LS_SE0) begin
                  state_nxt = EOP;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      if (usb_reset_det) begin
         state_nxt  = IDLE;
         active_nxt = 1'b0;
      end
   end

   // FSM state and receive datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         zero_cnt  <= '0;
         ones_cnt  <= '0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         prev_jk   <= LS_J;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_error  <= 1'b0;
         rx_active <= 1'b0;
      end else begin
         state     <= state_nxt;
         zero_cnt  <= zero_nxt;
         ones_cnt  <= ones_nxt;
         bit_cnt   <= bit_nxt;
         shift_q   <= shift_nxt;
         prev_jk   <= prev_nxt;
         rx_data   <= data_nxt;
         rx_valid  <= valid_nxt;
         rx_error  <= error_nxt;
         rx_active <= active_nxt;
      end
   end

   // SE0 duration counter, saturating at the bus-reset threshold
   always_comb begin
      se0_nxt_c = '0;
      if (line_state == LS_SE0) begin
         se0_nxt_c = (se0_cnt == SE0_CNT_W'(RESET_SE0_CYCLES)) ? se0_cnt : se0_cnt + SE0_CNT_W'(1);
      end
   end

   // Bus-reset detect register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         se0_cnt       <= '0;
         usb_reset_det <= 1'b0;
      end else begin
         se0_cnt       <= se0_nxt_c;
         usb_reset_det <= (se0_nxt_c == SE0_CNT_W'(RESET_SE0_CYCLES));
      end
   end

`ifdef USB_RX_ERRCNT_EN
   // Saturating count of rx_error pulses
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (rx_error && (err_count != '1)) begin
         err_count <= err_count + BYTE_W'(1);
      end
   end
`endif

endmodule
